// File: rtl/aer_spike_receiver.sv
`default_nettype none
// ============================================================================
// Module      : aer_spike_receiver
// Description : 4-phase AER event receiver feeding a small show-ahead event
//               buffer. Events are drained one per cycle into a saturating
//               8-bit synaptic current with optional exponential-style decay.
// Options     : define AER_REQ_SYNC_EN to pass aer_req through a 2-flop
//               synchronizer (asynchronous spike source).
// Revision    : 1.0 - initial release
// ============================================================================
module aer_spike_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAU_SHIFT  = 3,
  parameter int W_SHIFT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aer_req,
  input  logic [3:0] aer_w,
  input  logic       aer_pol,
  input  logic       decay_tick,
  output logic       aer_ack,
  output logic [7:0] i_syn,
  output logic       fifo_full,
  output logic       sat_flag
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  // --------------------------------------------------------------------------
  // Request input stage
  // --------------------------------------------------------------------------
  logic req_s;

`ifdef AER_REQ_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for a request that may be asynchronous to clk
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], aer_req};
  end

  assign req_s = sync_q[1];
`else
  assign req_s = aer_req;
`endif

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic       push;
  logic [CNT_W-1:0] count_q, count_d;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept only when the buffer has room, release on req drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_s && !fifo_full) state_d = ACK;
      ACK:     if (!req_s)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: push on the accepting edge, ack mirrors the ACK state
  always_comb begin
    push    = (state_q == IDLE) && req_s && !fifo_full;
    aer_ack = (state_q == ACK);
  end

  // --------------------------------------------------------------------------
  // Event buffer (show-ahead, circular)
  // --------------------------------------------------------------------------
  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             pop;
  logic [4:0]       head;

  assign pop  = (count_q != '0);
  assign head = mem[rd_ptr_q];

  // Event storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {aer_pol, aer_w};
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers; power-of-two depth wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Synaptic current datapath
  // --------------------------------------------------------------------------
  logic [7:0] i_syn_q, i_syn_d;
  logic       sat_q, sat_d;
  logic [7:0] dec, t;
  logic [9:0] wt, sum;
  logic       clamp;

  // Decay first, then apply the head event with saturation in 10-bit space
  always_comb begin
    dec     = decay_tick ? (i_syn_q >> TAU_SHIFT) : 8'd0;
    t       = i_syn_q - dec;
    wt      = {6'd0, head[3:0]} << W_SHIFT;
    sum     = {2'b00, t} + wt;
    i_syn_d = t;
    clamp   = 1'b0;
    if (pop) begin
      if (head[4]) begin
        if (sum > 10'd255) begin
          i_syn_d = 8'd255;
          clamp   = 1'b1;
        end else begin
          i_syn_d = sum[7:0];
        end
      end else begin
        if (wt > {2'b00, t}) begin
          i_syn_d = 8'd0;
          clamp   = 1'b1;
        end else begin
          i_syn_d = t - wt[7:0];
        end
      end
    end
    sat_d = sat_q | clamp;
  end

  // Current and sticky saturation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_syn_q <= 8'd0;
      sat_q   <= 1'b0;
    end else begin
      i_syn_q <= i_syn_d;
      sat_q   <= sat_d;
    end
  end

  assign i_syn    = i_syn_q;
  assign sat_flag = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_aer_spike_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_aer_spike_receiver
// Description : Directed self-checking bench for aer_spike_receiver.
//               Handshake latency expectations follow AER_REQ_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_spike_receiver;

`ifdef AER_REQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       aer_req;
  logic [3:0] aer_w;
  logic       aer_pol;
  logic       decay_tick;
  logic       aer_ack;
  logic [7:0] i_syn;
  logic       fifo_full;
  logic       sat_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_rises = 0;
  logic ack_prev = 1'b0;

  aer_spike_receiver #(.FIFO_DEPTH(4), .TAU_SHIFT(3), .W_SHIFT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .aer_req    (aer_req),
    .aer_w      (aer_w),
    .aer_pol    (aer_pol),
    .decay_tick (decay_tick),
    .aer_ack    (aer_ack),
    .i_syn      (i_syn),
    .fifo_full  (fifo_full),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  // Independent count of acknowledge rising edges
  always @(negedge clk) begin
    if (aer_ack === 1'b1 && ack_prev === 1'b0) ack_rises++;
    ack_prev = aer_ack;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; aer_req = 1'b0; decay_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < TMO && !hit; i++) begin
      @(negedge clk);
      if (aer_ack === lvl) hit = 1'b1;
    end
  endtask

  task automatic handshake(input logic [3:0] w, input logic pol);
    logic hit;
    @(negedge clk);
    aer_w = w; aer_pol = pol; aer_req = 1'b1;
    wait_ack(1'b1, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL hs_ack_rise: aer_ack=%b, required 1 within %0d cycles", aer_ack, TMO);
    end
    aer_req = 1'b0;
    wait_ack(1'b0, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL hs_ack_fall: aer_ack=%b, required 0 within %0d cycles", aer_ack, TMO);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; aer_req = 1'b0; decay_tick = 1'b0; aer_w = 4'd0; aer_pol = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (aer_ack !== 1'b0 || i_syn !== 8'd0 || fifo_full !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b i_syn=%0d full=%b sat=%b, required 0 0 0 0",
               aer_ack, i_syn, fifo_full, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    aer_w = 4'd5; aer_pol = 1'b1; aer_req = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (aer_ack !== (k == LAT)) begin
        n_fail++;
        $display("FAIL basic_ack_rise edge %0d: aer_ack=%b, required %b", k, aer_ack, (k == LAT));
      end
    end
    aer_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_checks++;
        if (i_syn !== 8'd20) begin
          n_fail++;
          $display("FAIL basic_i_syn: i_syn=%0d, required 20", i_syn);
        end
      end
      n_checks++;
      if (aer_ack !== (k < LAT)) begin
        n_fail++;
        $display("FAIL basic_ack_fall edge %0d: aer_ack=%b, required %b", k, aer_ack, (k < LAT));
      end
    end
    settle();
  endtask

  task automatic test_saturation();
    do_reset();
    handshake(4'd15, 1'b1);
    handshake(4'd15, 1'b1);
    handshake(4'd15, 1'b1);
    handshake(4'd5, 1'b1);
    settle();
    n_checks++;
    if (i_syn !== 8'd200 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_preload: i_syn=%0d sat=%b, required 200 0", i_syn, sat_flag);
    end
    handshake(4'd15, 1'b1);
    settle();
    n_checks++;
    if (i_syn !== 8'd255 || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clamp_hi: i_syn=%0d sat=%b, required 255 1", i_syn, sat_flag);
    end
    handshake(4'd15, 1'b0);
    settle();
    n_checks++;
    if (i_syn !== 8'd195 || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_sticky: i_syn=%0d sat=%b, required 195 1", i_syn, sat_flag);
    end
    handshake(4'd15, 1'b0);
    handshake(4'd15, 1'b0);
    handshake(4'd15, 1'b0);
    handshake(4'd15, 1'b0);
    settle();
    n_checks++;
    if (i_syn !== 8'd0 || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clamp_lo: i_syn=%0d sat=%b, required 0 1", i_syn, sat_flag);
    end
    do_reset();
    n_checks++;
    if (sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_cleared_by_rst: sat=%b, required 0", sat_flag);
    end
  endtask

  task automatic test_decay_inhib();
    logic hit;
    do_reset();
    handshake(4'd15, 1'b1);
    handshake(4'd5, 1'b0);
    settle();
    n_checks++;
    if (i_syn !== 8'd40) begin
      n_fail++;
      $display("FAIL dec_preload: i_syn=%0d, required 40", i_syn);
    end
    @(negedge clk);
    aer_w = 4'd3; aer_pol = 1'b0; aer_req = 1'b1;
    repeat (LAT) @(posedge clk);
    #1 decay_tick = 1'b1;
    @(posedge clk);
    #1 decay_tick = 1'b0;
    n_checks++;
    if (i_syn !== 8'd23 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_plus_inhib: i_syn=%0d sat=%b, required 23 0", i_syn, sat_flag);
    end
    aer_req = 1'b0;
    wait_ack(1'b0, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL dec_ack_fall: aer_ack=%b, required 0 within %0d cycles", aer_ack, TMO);
    end
    @(negedge clk) decay_tick = 1'b1;
    @(negedge clk) decay_tick = 1'b0;
    n_checks++;
    if (i_syn !== 8'd21) begin
      n_fail++;
      $display("FAIL dec_alone: i_syn=%0d, required 21", i_syn);
    end
  endtask

  task automatic test_decay_floor();
    do_reset();
    handshake(4'd2, 1'b1);
    settle();
    n_checks++;
    if (i_syn !== 8'd8) begin
      n_fail++;
      $display("FAIL floor_preload: i_syn=%0d, required 8", i_syn);
    end
    @(negedge clk) decay_tick = 1'b1;
    @(negedge clk) decay_tick = 1'b0;
    n_checks++;
    if (i_syn !== 8'd7) begin
      n_fail++;
      $display("FAIL floor_first_tick: i_syn=%0d, required 7", i_syn);
    end
    @(negedge clk) decay_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (i_syn !== 8'd7) begin
        n_fail++;
        $display("FAIL floor_hold tick %0d: i_syn=%0d, required 7", k, i_syn);
      end
    end
    decay_tick = 1'b0;
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    start = ack_rises;
    handshake(4'd10, 1'b1);
    handshake(4'd10, 1'b1);
    handshake(4'd10, 1'b1);
    handshake(4'd3,  1'b0);
    handshake(4'd0,  1'b1);
    handshake(4'd7,  1'b1);
    settle();
    n_checks++;
    if (ack_rises - start !== 6) begin
      n_fail++;
      $display("FAIL b2b_ack_count: acks=%0d, required 6", ack_rises - start);
    end
    n_checks++;
    if (i_syn !== 8'd136 || fifo_full !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_i_syn: i_syn=%0d full=%b sat=%b, required 136 0 0", i_syn, fifo_full, sat_flag);
    end
  endtask

  task automatic test_reset_mid();
    logic hit;
    do_reset();
    @(negedge clk);
    aer_w = 4'd15; aer_pol = 1'b1; aer_req = 1'b1;
    wait_ack(1'b1, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_ack_rise: aer_ack=%b, required 1 within %0d cycles", aer_ack, TMO);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (aer_ack !== 1'b0 || i_syn !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ack=%b i_syn=%0d, required 0 0", aer_ack, i_syn);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ack(1'b1, hit);
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_restart: aer_ack=%b, required 1 within %0d cycles", aer_ack, TMO);
    end
    aer_req = 1'b0;
    wait_ack(1'b0, hit);
    settle();
    n_checks++;
    if (!hit || i_syn !== 8'd60) begin
      n_fail++;
      $display("FAIL mid_duplicate: ack_fell=%b i_syn=%0d, required 1 60", hit, i_syn);
    end
  endtask

  initial begin
    rst = 1'b1; aer_req = 1'b0; aer_w = 4'd0; aer_pol = 1'b0; decay_tick = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_decay_inhib();
    test_decay_floor();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
